// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF / load-store requesters, the port arbiter and the
// unified memory port. The arbiter takes the slave view (it serves both
// requesters and drives the memory side). The surrounding pipeline, memory
// and testbench take the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    // Instruction-fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // Load/store requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // Memory port
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    // Owner of the current transaction for the memory-side muxes (0 = IF, 1 = D)
    logic          sel;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output sel
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  sel
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter. Picks IF or load/store, registers the winner's
// payload onto the memory bus, keeps exactly one transaction outstanding and
// routes grant/response back to the owner. Grants and responses are
// combinational pass-throughs of mem_gnt / mem_rvalid, gated by state and owner.
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int PRIO_MODE = 0     // 0 = round-robin, 1 = D always beats IF
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW         = DW / 8;
    localparam bit FIXED_PRIO = (PRIO_MODE == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // free: arbitrate this cycle
        ST_REQ  = 2'd1,   // mem_req high, waiting for mem_gnt
        ST_WAIT = 2'd2    // granted, waiting for mem_rvalid
    } state_t;

    // Registered state and memory-side outputs
    state_t        state_reg;
    logic          last_d_reg;      // 1 = D was served last (tie goes to IF)
    logic          sel_reg;
    logic          mem_req_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [BW-1:0] mem_be_reg;

    // Arbitration result and winner payload for this cycle
    logic          any_req;
    logic          win_d;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [BW-1:0] win_be;

    // Handshake events that only count in the matching state
    logic          gnt_fire;
    logic          rsp_fire;

    // D wins when it is the only requester, when priority is fixed, or when
    // IF was served last; otherwise IF wins.
    assign any_req   = bus.if_req | bus.d_req;
    assign win_d     = bus.d_req & (~bus.if_req | FIXED_PRIO | ~last_d_reg);
    assign win_we    = win_d & bus.d_we;
    assign win_addr  = win_d ? bus.d_addr : bus.if_addr;
    assign win_wdata = win_d ? bus.d_wdata : '0;

    // Byte enables: instruction fetches always read the full word
    genvar gi;
    generate
        for (gi = 0; gi < BW; gi = gi + 1) begin : g_be
            assign win_be[gi] = win_d ? bus.d_be[gi] : 1'b1;
        end
    endgenerate

    // mem_gnt is only meaningful while requesting, mem_rvalid only while waiting
    assign gnt_fire = (state_reg == ST_REQ)  & bus.mem_gnt;
    assign rsp_fire = (state_reg == ST_WAIT) & bus.mem_rvalid;

    // Transaction FSM with registered memory-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            last_d_reg    <= 1'b1;
            sel_reg       <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= win_we;
                        mem_addr_reg  <= win_addr;
                        mem_wdata_reg <= win_wdata;
                        mem_be_reg    <= win_be;
                        sel_reg       <= win_d;
                        last_d_reg    <= win_d;
                        state_reg     <= ST_REQ;
                    end else begin
                        mem_req_reg   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Payload stays put until memory accepts it
                    if (bus.mem_gnt) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Loads and stores both finish on the response beat
                    if (bus.mem_rvalid) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs straight from registers
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_be    = mem_be_reg;
    assign bus.sel       = sel_reg;

    // Owner-steered grant and response; the other port sees zeros
    assign bus.if_gnt    = gnt_fire & ~sel_reg;
    assign bus.d_gnt     = gnt_fire &  sel_reg;
    assign bus.if_rvalid = rsp_fire & ~sel_reg;
    assign bus.d_rvalid  = rsp_fire &  sel_reg;
    assign bus.if_rdata  = (rsp_fire & ~sel_reg) ? bus.mem_rdata : '0;
    assign bus.d_rdata   = (rsp_fire &  sel_reg) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
// A round-robin and a fixed-priority instance see identical inputs.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_fp ();

    // The fixed-priority instance mirrors every input of the round-robin one
    assign bus_fp.if_req     = bus.if_req;
    assign bus_fp.if_addr    = bus.if_addr;
    assign bus_fp.d_req      = bus.d_req;
    assign bus_fp.d_we       = bus.d_we;
    assign bus_fp.d_addr     = bus.d_addr;
    assign bus_fp.d_wdata    = bus.d_wdata;
    assign bus_fp.d_be       = bus.d_be;
    assign bus_fp.mem_gnt    = bus.mem_gnt;
    assign bus_fp.mem_rvalid = bus.mem_rvalid;
    assign bus_fp.mem_rdata  = bus.mem_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(1)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp.slave)
    );

    // Control snapshot: {mem_req, if_gnt, if_rvalid, d_gnt, d_rvalid}
    function automatic logic [4:0] ctl_rr();
        return {bus.mem_req, bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid};
    endfunction

    function automatic logic [4:0] ctl_fp();
        return {bus_fp.mem_req, bus_fp.if_gnt, bus_fp.if_rvalid, bus_fp.d_gnt, bus_fp.d_rvalid};
    endfunction

    task automatic clear_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_be       = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset holds everything at zero even with all inputs asserted
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.if_addr = 32'h44;
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b0 || bus.sel !== 1'b0 || bus.mem_we !== 1'b0)
            $display("FAIL reset_ctl_rr: got ctl=%b sel=%b we=%b want 0", ctl_rr(), bus.sel, bus.mem_we);
        if (ctl_rr() !== 5'b0 || bus.sel !== 1'b0 || bus.mem_we !== 1'b0) n_err++;
        n_vec++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_rdata, bus.d_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data_rr: got addr=%h wdata=%h be=%h ird=%h drd=%h want 0",
                     bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_rdata, bus.d_rdata);
        end
        n_vec++;
        if (ctl_fp() !== 5'b0 || bus_fp.sel !== 1'b0 || bus_fp.mem_addr !== '0) begin
            n_err++;
            $display("FAIL reset_fp: got ctl=%b sel=%b addr=%h want 0", ctl_fp(), bus_fp.sel, bus_fp.mem_addr);
        end
        clear_inputs();
        rst = 1'b0;
        $display("reset: checked");
    endtask

    // Single IF read: mem_req+if_gnt one cycle after the request, data the next
    task automatic test_if_read();
        do_reset();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_gnt = 1'b1;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00000) begin n_err++; $display("FAIL if_read_c0: got %b want 00000", ctl_rr()); end
        @(negedge clk);
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b11000) begin n_err++; $display("FAIL if_read_c1_ctl: got %b want 11000", ctl_rr()); end
        n_vec++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_be, bus.sel} !== {32'h100, 1'b0, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL if_read_c1_bus: got addr=%h we=%b be=%h sel=%b want 100/0/f/0",
                     bus.mem_addr, bus.mem_we, bus.mem_be, bus.sel);
        end
        @(negedge clk);
        bus.if_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00100 || bus.if_rdata !== 32'hDEADBEEF || bus.d_rdata !== '0) begin
            n_err++;
            $display("FAIL if_read_c2: got ctl=%b ird=%h drd=%h want 00100/deadbeef/0",
                     ctl_rr(), bus.if_rdata, bus.d_rdata);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00000 || bus.if_rdata !== '0) begin
            n_err++;
            $display("FAIL if_read_c3: got ctl=%b ird=%h want 00000/0", ctl_rr(), bus.if_rdata);
        end
        $display("if_read: addr=100 data=deadbeef");
    endtask

    // Both requesters held: round-robin alternates starting with IF, fixed priority always D
    task automatic test_prio();
        logic rr_q[$];
        logic fp_q[$];
        logic exp_rr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_we = 1'b0; bus.d_be = 4'hF;
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
        for (int c = 0; c < 20 && (rr_q.size() < 4 || fp_q.size() < 4); c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.if_gnt)    rr_q.push_back(1'b0);
            if (bus.d_gnt)     rr_q.push_back(1'b1);
            if (bus_fp.if_gnt) fp_q.push_back(1'b0);
            if (bus_fp.d_gnt)  fp_q.push_back(1'b1);
            if (bus.if_gnt || bus.d_gnt) begin
                n_vec++;
                if (bus.mem_addr !== (bus.d_gnt ? 32'h300 : 32'h200)) begin
                    n_err++;
                    $display("FAIL prio_addr: got %h for owner d=%b", bus.mem_addr, bus.d_gnt);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= rr_q.size()) begin
                n_err++; $display("FAIL prio_rr_%0d: got no grant want %b", i, exp_rr[i]);
            end else if (rr_q[i] !== exp_rr[i]) begin
                n_err++; $display("FAIL prio_rr_%0d: got owner %b want %b", i, rr_q[i], exp_rr[i]);
            end
            n_vec++;
            if (i >= fp_q.size()) begin
                n_err++; $display("FAIL prio_fp_%0d: got no grant want 1", i);
            end else if (fp_q[i] !== 1'b1) begin
                n_err++; $display("FAIL prio_fp_%0d: got owner %b want 1", i, fp_q[i]);
            end
        end
        clear_inputs();
        $display("prio: rr grants=%0d fp grants=%0d", rr_q.size(), fp_q.size());
    endtask

    // Store stalled three cycles by memory: payload stable, d_gnt only on the gnt cycle
    task automatic test_store_stall();
        do_reset();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20;
        bus.d_wdata = 32'h11223344; bus.d_be = 4'b0011;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.mem_gnt = (c == 4);
            #1;
            n_vec++;
            if (ctl_rr() !== ((c == 4) ? 5'b10010 : 5'b10000)) begin
                n_err++; $display("FAIL store_ctl_c%0d: got %b want %b", c, ctl_rr(), (c == 4) ? 5'b10010 : 5'b10000);
            end
            n_vec++;
            if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we, bus.sel} !==
                {32'h20, 32'h11223344, 4'b0011, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL store_bus_c%0d: got addr=%h wd=%h be=%b we=%b sel=%b want 20/11223344/0011/1/1",
                         c, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we, bus.sel);
            end
        end
        @(negedge clk);
        bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000A5A5;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00001 || bus.d_rdata !== 32'h0000A5A5 || bus.if_rdata !== '0) begin
            n_err++;
            $display("FAIL store_ack: got ctl=%b drd=%h ird=%h want 00001/a5a5/0", ctl_rr(), bus.d_rdata, bus.if_rdata);
        end
        clear_inputs();
        $display("store_stall: addr=20 wdata=11223344 be=0011");
    endtask

    // D request raised while an IF transaction waits for data
    task automatic test_pending();
        do_reset();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h180; bus.mem_gnt = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b11000) begin n_err++; $display("FAIL pend_if_gnt: got %b want 11000", ctl_rr()); end
        @(negedge clk);
        bus.if_req = 1'b0; bus.mem_gnt = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_be = 4'hF;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00000) begin n_err++; $display("FAIL pend_wait: got %b want 00000", ctl_rr()); end
        @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00100 || bus.if_rdata !== 32'h12345678) begin
            n_err++; $display("FAIL pend_if_rsp: got ctl=%b ird=%h want 00100/12345678", ctl_rr(), bus.if_rdata);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00000) begin n_err++; $display("FAIL pend_bubble: got %b want 00000", ctl_rr()); end
        @(negedge clk);
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b10010 || bus.sel !== 1'b1 || bus.mem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL pend_d_gnt: got ctl=%b sel=%b addr=%h want 10010/1/40", ctl_rr(), bus.sel, bus.mem_addr);
        end
        @(negedge clk);
        bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55AA55AA;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00001 || bus.d_rdata !== 32'h55AA55AA || bus.if_rdata !== '0) begin
            n_err++;
            $display("FAIL pend_d_rsp: got ctl=%b drd=%h ird=%h want 00001/55aa55aa/0", ctl_rr(), bus.d_rdata, bus.if_rdata);
        end
        clear_inputs();
        $display("pending: IF 180 then D 40");
    endtask

    // Reset while waiting drops the response; the next request is served normally
    task automatic test_reset_midflight();
        do_reset();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.mem_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.if_req = 1'b0; bus.mem_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000BAD;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b0 || bus.if_rdata !== '0 || bus.mem_addr !== '0 || bus.mem_be !== '0 || bus.sel !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_drop: got ctl=%b ird=%h addr=%h be=%h sel=%b want all 0",
                     ctl_rr(), bus.if_rdata, bus.mem_addr, bus.mem_be, bus.sel);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h84; bus.mem_gnt = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b11000 || bus.mem_addr !== 32'h84) begin
            n_err++; $display("FAIL midrst_next_gnt: got ctl=%b addr=%h want 11000/84", ctl_rr(), bus.mem_addr);
        end
        @(negedge clk);
        bus.if_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000600D;
        #1;
        n_vec++;
        if (ctl_rr() !== 5'b00100 || bus.if_rdata !== 32'h0000600D) begin
            n_err++; $display("FAIL midrst_next_rsp: got ctl=%b ird=%h want 00100/600d", ctl_rr(), bus.if_rdata);
        end
        clear_inputs();
        $display("reset_midflight: dropped response, IF 84 served");
    endtask

    // Random requesters and memory timing against a transaction-level model:
    // at most one transaction in flight, a free port arbitrates the pending
    // requests, the winner's payload is presented until granted, and the
    // owner alone sees the grant and the response.
    task automatic test_random();
        bit          t_valid = 1'b0, t_granted = 1'b0, t_owner = 1'b0, t_we = 1'b0;
        bit          last_d = 1'b1;
        logic [31:0] t_addr = '0, t_wdata = '0;
        logic [3:0]  t_be = '0;
        bit          if_pend = 1'b0, d_pend = 1'b0, d_we_v = 1'b0;
        logic [31:0] ia = '0, da = '0, dw = '0;
        logic [3:0]  dbe = '0;
        logic [31:0] marr [8];
        logic [31:0] drv, exp_rd;
        bit          g, rv, e_req, e_ig, e_iv, e_dg, e_dv;
        int          ntx = 0;
        do_reset();
        for (int i = 0; i < 8; i++) marr[i] = $urandom;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1'b1;
                ia = 32'h1000 + 32'($urandom_range(7)) * 4;
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1'b1;
                da = 32'h1000 + 32'($urandom_range(7)) * 4;
                d_we_v = 1'($urandom_range(1));
                dw = $urandom;
                dbe = 4'($urandom_range(15));
            end
            g  = 1'($urandom_range(1));
            rv = 1'($urandom_range(1));
            drv = $urandom;
            if (t_valid && t_granted && !t_we) drv = marr[t_addr[4:2]];
            bus.if_req = if_pend; bus.if_addr = ia;
            bus.d_req = d_pend; bus.d_we = d_we_v; bus.d_addr = da; bus.d_wdata = dw; bus.d_be = dbe;
            bus.mem_gnt = g; bus.mem_rvalid = rv; bus.mem_rdata = drv;
            #1;
            e_req = t_valid && !t_granted;
            e_ig  = e_req && g && !t_owner;
            e_dg  = e_req && g && t_owner;
            e_iv  = t_valid && t_granted && rv && !t_owner;
            e_dv  = t_valid && t_granted && rv && t_owner;
            exp_rd = t_we ? drv : marr[t_addr[4:2]];
            n_vec++;
            if (ctl_rr() !== {e_req, e_ig, e_iv, e_dg, e_dv}) begin
                n_err++;
                $display("FAIL rand_ctl cyc %0d: got %b want %b", cyc, ctl_rr(), {e_req, e_ig, e_iv, e_dg, e_dv});
            end
            if (t_valid) begin
                n_vec++;
                if (bus.sel !== t_owner) begin
                    n_err++; $display("FAIL rand_sel cyc %0d: got %b want %b", cyc, bus.sel, t_owner);
                end
            end
            if (e_req) begin
                n_vec++;
                if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be} !== {t_addr, t_we, t_wdata, t_be}) begin
                    n_err++;
                    $display("FAIL rand_bus cyc %0d: got %h/%b/%h/%h want %h/%b/%h/%h", cyc,
                             bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be, t_addr, t_we, t_wdata, t_be);
                end
            end
            n_vec++;
            if (bus.if_rdata !== (e_iv ? exp_rd : 32'h0) || bus.d_rdata !== (e_dv ? exp_rd : 32'h0)) begin
                n_err++;
                $display("FAIL rand_rdata cyc %0d: got if=%h d=%h want if=%h d=%h", cyc,
                         bus.if_rdata, bus.d_rdata, e_iv ? exp_rd : 32'h0, e_dv ? exp_rd : 32'h0);
            end
            // Advance the model across the coming rising edge
            if (t_valid && !t_granted) begin
                if (g) begin
                    t_granted = 1'b1;
                    if (t_owner) d_pend = 1'b0;
                    else         if_pend = 1'b0;
                end
            end else if (t_valid) begin
                if (rv) begin
                    if (t_we)
                        for (int b = 0; b < 4; b++)
                            if (t_be[b]) marr[t_addr[4:2]][8*b +: 8] = t_wdata[8*b +: 8];
                    ntx++;
                    $display("txn %0d %s addr=%h we=%0b data=%h", ntx, t_owner ? "D " : "IF",
                             t_addr, t_we, t_we ? t_wdata : exp_rd);
                    t_valid = 1'b0;
                end
            end else if (if_pend || d_pend) begin
                t_owner   = d_pend && (!if_pend || !last_d);
                last_d    = t_owner;
                t_valid   = 1'b1;
                t_granted = 1'b0;
                t_addr    = t_owner ? da : ia;
                t_we      = t_owner && d_we_v;
                t_wdata   = t_owner ? dw : 32'h0;
                t_be      = t_owner ? dbe : 4'hF;
            end
        end
        clear_inputs();
        $display("random: %0d transactions completed", ntx);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_if_read();
        test_prio();
        test_store_stall();
        test_pending();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
